pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic inter-stage pipeline register for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Replaces hand-written per-field stall/flush registers with one parametrised stage.
//  Fields are split into CTRL and DATA; a 2-entry skid buffer gives a valid/ready handshake.
//  Back-pressure is therefore registered and never combinational from out_ready to in_ready.
// PARAMETERS
//  CTRL_W   8   width of control bundle (branch, memread, memtoreg, aluop, ...); flushed to 0
//  DATA_W   64  width of data bundle (imme, rs data, reg indices, ...); never cleared by flush
//  CNT_W    16  width of bubble counter (used only with PIPE_BUBBLE_CNT_EN)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       squash all buffered beats (branch mispredict / trap)
//  in_valid   in   1       upstream beat valid
//  in_ready   out  1       stage can accept a beat this cycle (registered)
//  in_ctrl    in   CTRL_W  upstream control bundle
//  in_data    in   DATA_W  upstream data bundle
//  out_valid  out  1       beat presented downstream
//  out_ready  in   1       downstream accepts the beat
//  out_ctrl   out  CTRL_W  control of head beat; 0 whenever out_valid=0
//  out_data   out  DATA_W  data of head beat; holds last value when out_valid=0
//  bubble_cnt out  CNT_W   only with PIPE_BUBBLE_CNT_EN
// BEHAVIOUR
//  - Storage: main slot (drives out_*) + skid slot. FSM: EMPTY, ONE (main only), FULL (both).
//  - Accept: in_valid & in_ready. Pop: out_valid & out_ready. Latency accept->out_valid: 1 clk.
//  - in_ready = (state != FULL), from a flop. out_valid = (state != EMPTY).
//  - EMPTY: accept -> ONE, beat into main.
//  - ONE:
//      accept & pop   -> ONE, beat into main.
//      accept & !pop  -> FULL, beat into skid.
//      pop & !accept  -> EMPTY.
//  - FULL (in_ready=0): pop -> ONE, skid moves to main; no accept possible.
//  - Order strictly FIFO; no beat lost or duplicated outside flush.
//  - Emptying main slot clears main ctrl to 0. Data regs load only on writes, otherwise hold.
//  - flush (sync): state -> EMPTY, main+skid ctrl -> 0, data hold.
//      Overrides accept and pop in the same cycle; the beat offered that cycle is dropped.
//      in_ready = 1 on the following cycle.
//  - reset: state EMPTY, in_ready=0 during reset cycle then 1, out_valid=0, out_ctrl=0,
//    out_data=0, bubble_cnt=0. Reset has priority over flush.
//  - A mid-operation reset discards all beats identically to flush.
//  - in_ctrl/in_data are sampled only on accept; X on them when in_valid=0 must not propagate.
// CONFIGURATION
//  PIPE_BUBBLE_CNT_EN defined:
//    bubble_cnt increments on each clk with out_ready=1 & out_valid=0 and saturates at all-ones.
//    Cleared by reset only, not by flush.
//  PIPE_BUBBLE_CNT_EN undefined: no port, no counter logic.
// STRUCTURE
//  Shared package pipe_pkg: FSM state enum {EMPTY, ONE, FULL} (2 bits) and per-stage
//    CTRL_W/DATA_W constants (e.g. ID_EX_CTRL_W=10).
//  Optional sub-module pipe_bubble_ctr (saturating counter), instantiated under the macro.
//  The core FSM plus both slots stays in this module.
// TESTING
//  1 Reset held 2 clk with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0;
//    in_ready=1 the cycle after reset drops.
//  2 Stream 0x01..0x08 with out_ready=1 every clk -> out_data follows 1 clk later in order;
//    in_ready never drops.
//  3 Push A,B,C with out_ready=0 -> FULL after B, in_ready=0, C held upstream.
//    Raise out_ready -> A,B,C emerge in order, no loss.
//  4 FULL with ctrl=0xFF, assert flush together with in_valid=1, D=0x55 ->
//    next clk out_valid=0, out_ctrl=0, out_data unchanged, D never emerges.
//  5 Reset asserted while in ONE -> next clk EMPTY; the following pushed beat alone emerges.
//  6 (PIPE_BUBBLE_CNT_EN) 5 clk out_ready=1 with no input -> bubble_cnt=5;
//    flush leaves 5; with CNT_W=4, 20 idle clk -> 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-buffer FSM encoding and per-stage bundle widths
package pipe_pkg;
  typedef logic [1:0] state_t;
  localparam state_t EMPTY = 2'd0;
  localparam state_t ONE = 2'd1;
  localparam state_t FULL = 2'd2;
  localparam int IF_ID_CTRL_W = 4;
  localparam int IF_ID_DATA_W = 64;
  localparam int ID_EX_CTRL_W = 10;
  localparam int ID_EX_DATA_W = 128;
  localparam int EX_MEM_CTRL_W = 6;
  localparam int EX_MEM_DATA_W = 96;
  localparam int MEM_WB_CTRL_W = 3;
  localparam int MEM_WB_DATA_W = 64;
endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready handshake bundle between pipeline stages
interface pipe_stage_buf_if #(parameter int CTRL_W = 8, parameter int DATA_W = 64);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  modport master(output in_valid, in_ctrl, in_data, out_ready, input in_ready, out_valid, out_ctrl, out_data);
  modport slave(input in_valid, in_ctrl, in_data, out_ready, output in_ready, out_valid, out_ctrl, out_data);
endinterface

// File: rtl/pipe_stage_buf_bubble_ctr.sv
// pipe_bubble_ctr: saturating event counter, cleared only by reset
module pipe_bubble_ctr #(parameter int W = 16) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: 2-entry skid pipeline register with flushable ctrl and held data
// Optional bubble counter port/logic enabled by defining PIPE_BUBBLE_CNT_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
`ifdef PIPE_BUBBLE_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic clk,
  input logic reset,
  input logic flush,
  pipe_stage_buf_if.slave bus
`ifdef PIPE_BUBBLE_CNT_EN
  , output logic [CNT_W-1:0] bubble_cnt
`endif
);
  state_t state, nxt;
  logic rdy_q, acc, pop;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  assign acc = bus.in_valid & rdy_q;
  assign pop = (state != EMPTY) & bus.out_ready;
  always_comb
    nxt = state == EMPTY ? (acc ? ONE : EMPTY) :
          state == ONE   ? (acc && !pop ? FULL : pop && !acc ? EMPTY : ONE) :
                           (pop ? ONE : FULL);
  // in_ready is a flop of the next state, so out_ready never reaches it combinationally
  always_ff @(posedge clk)
    if (reset) begin
      state <= EMPTY;
      rdy_q <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= nxt;
      rdy_q <= nxt != FULL;
      if (state == FULL && pop) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
        skid_ctrl <= '0;
      end else if (acc && (state == EMPTY || pop)) begin
        main_ctrl <= bus.in_ctrl;
        main_data <= bus.in_data;
      end else if (pop) main_ctrl <= '0;
      if (acc && state == ONE && !pop) begin
        skid_ctrl <= bus.in_ctrl;
        skid_data <= bus.in_data;
      end
    end
  assign bus.in_ready = rdy_q;
  assign bus.out_valid = state != EMPTY;
  assign bus.out_ctrl = main_ctrl;
  assign bus.out_data = main_data;
`ifdef PIPE_BUBBLE_CNT_EN
  pipe_bubble_ctr #(.W(CNT_W)) u_bubble (
    .clk(clk),
    .reset(reset),
    .inc(bus.out_ready & (state == EMPTY)),
    .cnt(bubble_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scenario tasks plus random traffic against a queue-based reference model
module tb_pipe_stage_buf;
  localparam int CW = 8;
  localparam int DW = 64;
  typedef struct packed {logic [CW-1:0] c; logic [DW-1:0] d;} beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) bus();
`ifdef PIPE_BUBBLE_CNT_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0] bubble_cnt;
  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus), .bubble_cnt(bubble_cnt));
`else
  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus));
`endif
  // reference model: a FIFO of at most two beats plus the last value seen at the head
  beat_t q[$];
  logic m_rdy = 1'b0;
  logic [DW-1:0] m_last = '0;
  int m_cnt = 0;
  logic m_acc;
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_rdy = 1'b0;
      m_last = '0;
      m_cnt = 0;
    end else begin
      if (bus.out_ready && q.size() == 0 && m_cnt < 15) m_cnt++;
      if (flush) q.delete();
      else begin
        m_acc = bus.in_valid && m_rdy;
        if (bus.out_ready && q.size() > 0) void'(q.pop_front());
        if (m_acc) q.push_back({bus.in_ctrl, bus.in_data});
      end
      m_rdy = q.size() < 2;
      if (q.size() > 0) m_last = q[0].d;
    end
  end
  wire [DW+CW+1:0] obs = {bus.out_valid, bus.in_ready, bus.out_ctrl, bus.out_data};
  function automatic logic [DW+CW+1:0] model_out();
    return {q.size() != 0, m_rdy, q.size() != 0 ? q[0].c : {CW{1'b0}}, m_last};
  endfunction
  task automatic drive(input logic v, input logic r, input logic f, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.out_ready = r;
    flush = f;
    bus.in_ctrl = c;
    bus.in_data = d;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1, 0, 8'hA5, 64'h1234);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_state got %h exp 0", obs); end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_cmp++;
    if (obs !== model_out()) begin n_err++; $display("FAIL reset_model got %h exp %h", obs, model_out()); end
  endtask
  task automatic test_stream();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== model_out()) begin n_err++; $display("FAIL stream_model got %h exp %h", obs, model_out()); end
      if (i >= 2 && i <= 9) begin
        n_cmp++;
        if (bus.out_data !== 64'(i - 1) || bus.in_ready !== 1'b1)
          begin n_err++; $display("FAIL stream_beat%0d got data %h rdy %b exp data %h rdy 1", i - 1, bus.out_data, bus.in_ready, i - 1); end
      end
      drive(i <= 8, 1, 0, 8'(i), 64'(i));
    end
  endtask
  task automatic test_full();
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_v[3];
    logic c_pend = 1'b1;
    exp_v[0] = {$urandom, $urandom};
    exp_v[1] = {$urandom, $urandom};
    exp_v[2] = {$urandom, $urandom};
    @(negedge clk); drive(0, 0, 1, 0, 0);
    @(negedge clk); drive(1, 0, 0, 8'h11, exp_v[0]);
    @(negedge clk); drive(1, 0, 0, 8'h22, exp_v[1]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_data !== exp_v[0] || bus.out_valid !== 1'b1)
        begin n_err++; $display("FAIL full_hold got rdy %b vld %b data %h exp rdy 0 vld 1 data %h", bus.in_ready, bus.out_valid, bus.out_data, exp_v[0]); end
      drive(1, 0, 0, 8'h33, exp_v[2]);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== model_out()) begin n_err++; $display("FAIL full_model got %h exp %h", obs, model_out()); end
      if (bus.out_valid) got.push_back(bus.out_data);
      drive(c_pend, 1, 0, 8'h33, exp_v[2]);
      if (c_pend && m_rdy) c_pend = 1'b0;
    end
    n_cmp++;
    if (got.size() != 3) begin n_err++; $display("FAIL full_count got %0d exp 3", got.size()); end
    else for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (got[k] !== exp_v[k]) begin n_err++; $display("FAIL full_order%0d got %h exp %h", k, got[k], exp_v[k]); end
    end
  endtask
  task automatic test_flush();
    logic [DW-1:0] held;
    @(negedge clk); drive(0, 0, 1, 0, 0);
    @(negedge clk); drive(1, 0, 0, 8'hFF, 64'hAAAA);
    @(negedge clk); drive(1, 0, 0, 8'hFF, 64'hBBBB);
    @(negedge clk);
    held = bus.out_data;
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_ctrl !== 8'hFF) begin n_err++; $display("FAIL flush_pre got rdy %b ctrl %h exp rdy 0 ctrl ff", bus.in_ready, bus.out_ctrl); end
    drive(1, 1, 1, 8'hFF, 64'h55);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0 || bus.out_data !== held || bus.in_ready !== 1'b1)
      begin n_err++; $display("FAIL flush_post got vld %b ctrl %h data %h rdy %b exp 0 00 %h 1", bus.out_valid, bus.out_ctrl, bus.out_data, bus.in_ready, held); end
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || obs !== model_out()) begin n_err++; $display("FAIL flush_drop got %h exp %h", obs, model_out()); end
    end
  endtask
  task automatic test_reset_mid();
    logic [DW-1:0] got[$];
    logic y_pend = 1'b1;
    @(negedge clk); drive(0, 0, 1, 0, 0);
    @(negedge clk); drive(1, 0, 0, 8'h0C, 64'hDEAD);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_one got vld %b exp 1", bus.out_valid); end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL rmid_empty got %h exp 0", obs); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== model_out()) begin n_err++; $display("FAIL rmid_model got %h exp %h", obs, model_out()); end
      if (bus.out_valid) got.push_back(bus.out_data);
      drive(y_pend, 1, 0, 8'h0D, 64'hBEEF);
      if (y_pend && m_rdy) y_pend = 1'b0;
    end
    n_cmp++;
    if (got.size() != 1 || got[0] !== 64'hBEEF) begin n_err++; $display("FAIL rmid_out got %0d beats first %h exp 1 beat beef", got.size(), got.size() ? got[0] : '0); end
  endtask
  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== model_out()) begin n_err++; $display("FAIL random_cyc%0d got %h exp %h", k, obs, model_out()); end
      reset = $urandom_range(0, 99) == 0;
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            8'($urandom), {$urandom, $urandom});
    end
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1, 0, 0, 0);
  endtask
`ifdef PIPE_BUBBLE_CNT_EN
  task automatic test_bubble();
    @(negedge clk); reset = 1'b1; drive(0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0; drive(0, 1, 0, 0, 0);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bubble_cnt !== 4'd5 || 32'(bubble_cnt) !== m_cnt) begin n_err++; $display("FAIL bubble_five got %0d exp 5", bubble_cnt); end
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (bubble_cnt !== 4'd5) begin n_err++; $display("FAIL bubble_flush got %0d exp 5", bubble_cnt); end
    drive(0, 1, 0, 0, 0);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (bubble_cnt !== 4'd15 || 32'(bubble_cnt) !== m_cnt) begin n_err++; $display("FAIL bubble_sat got %0d exp 15", bubble_cnt); end
  endtask
`endif
  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef PIPE_BUBBLE_CNT_EN
    test_bubble();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
